// File: rtl/fixed_point_alu_if.sv
// Request/response bundle between the execute stage and the fixed-point unit.
interface fixed_point_alu_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       operation;
  logic [WIDTH-1:0] operand_1;
  logic [WIDTH-1:0] operand_2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             overflow;
  logic             error;

  modport master (output start, operation, operand_1, operand_2,
                  input  busy, done, result, overflow, error);
  modport slave  (input  start, operation, operand_1, operand_2,
                  output busy, done, result, overflow, error);
endinterface

// File: rtl/fixed_point_alu.sv
// Signed saturating fixed-point ADD/SUB/MUL/SQRT; operands latched when start is seen with busy=0.
// Latency: ADD/SUB 2, MUL (W/C)^2+2, SQRT (W+F)/2+1, illegal 1; start while busy is dropped.
module fixed_point_alu #(
  parameter int WIDTH     = 32,
  parameter int FBITS     = 10,
  parameter int MUL_CHUNK = 16
) (
  input  logic clk,
  input  logic reset,
  fixed_point_alu_if.slave bus
);
  localparam int N    = WIDTH / MUL_CHUNK;
  localparam int CW   = (N > 1) ? $clog2(N) : 1;
  localparam int ITER = (WIDTH + FBITS) / 2;
  localparam int ITW  = $clog2(ITER + 1);
  localparam int RADW = WIDTH + FBITS;
  localparam int RMW  = ITER + 3;
  localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ADDSUB, MUL_PP, MUL_SUM, SQRT_IT, FINISH} state_t;
  state_t state_q, state_d;

  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q, res_q;
  logic               ovf_q, err_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CW-1:0]      i_q, j_q;
  logic [RADW-1:0]    rad_q;
  logic [RMW-1:0]     rem_q;
  logic [ITER-1:0]    root_q;
  logic [ITW-1:0]     it_q;

  logic [WIDTH:0]       sum_ext;
  logic [WIDTH-1:0]     as_res, mag_a, mag_b, mul_res;
  logic                 as_ovf, mul_ovf, mul_neg;
  logic [2*MUL_CHUNK-1:0] pp;
  logic [2*WIDTH-1:0]   pp_sh, mag_sh;
  logic [RMW-1:0]       rem_sh, trial, rem_nxt;
  logic [ITER-1:0]      root_nxt;
  logic                 ge;

  assign bus.busy = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start) begin
        case (bus.operation)
          3'd0, 3'd1: state_d = ADDSUB;
          3'd2:       state_d = MUL_PP;
          3'd3:       state_d = SQRT_IT;
          default:    state_d = FINISH;
        endcase
      end
      ADDSUB:  state_d = FINISH;
      MUL_PP:  if (i_q == CW'(N-1) && j_q == CW'(N-1)) state_d = MUL_SUM;
      MUL_SUM: state_d = FINISH;
      SQRT_IT: if (it_q == ITW'(ITER-1)) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sum_ext = op_q[0] ? ({a_q[WIDTH-1], a_q} - {b_q[WIDTH-1], b_q})
                      : ({a_q[WIDTH-1], a_q} + {b_q[WIDTH-1], b_q});
    as_ovf  = sum_ext[WIDTH] ^ sum_ext[WIDTH-1];
    as_res  = as_ovf ? (sum_ext[WIDTH] ? MINV : MAXV) : sum_ext[WIDTH-1:0];

    mag_a   = a_q[WIDTH-1] ? -a_q : a_q;
    mag_b   = b_q[WIDTH-1] ? -b_q : b_q;
    mul_neg = a_q[WIDTH-1] ^ b_q[WIDTH-1];
    pp      = (2*MUL_CHUNK)'(mag_a[int'(i_q)*MUL_CHUNK +: MUL_CHUNK])
            * (2*MUL_CHUNK)'(mag_b[int'(j_q)*MUL_CHUNK +: MUL_CHUNK]);
    pp_sh   = (2*WIDTH)'(pp) << ((int'(i_q) + int'(j_q)) * MUL_CHUNK);
    mag_sh  = acc_q >> FBITS;
    // Negative side may reach exactly 2^(W-1) without clamping.
    if (mul_neg) begin
      mul_ovf = mag_sh > (2*WIDTH)'(MINV);
      mul_res = mul_ovf ? MINV : -mag_sh[WIDTH-1:0];
    end else begin
      mul_ovf = mag_sh > (2*WIDTH)'(MAXV);
      mul_res = mul_ovf ? MAXV : mag_sh[WIDTH-1:0];
    end

    rem_sh   = {rem_q[RMW-3:0], rad_q[RADW-1 -: 2]};
    trial    = RMW'({root_q, 2'b01});
    ge       = rem_sh >= trial;
    rem_nxt  = ge ? (rem_sh - trial) : rem_sh;
    root_nxt = {root_q[ITER-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q <= '0; a_q <= '0; b_q <= '0; res_q <= '0; ovf_q <= 1'b0; err_q <= 1'b0;
      acc_q <= '0; i_q <= '0; j_q <= '0;
      rad_q <= '0; rem_q <= '0; root_q <= '0; it_q <= '0;
      bus.done <= 1'b0; bus.result <= '0; bus.overflow <= 1'b0; bus.error <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          op_q   <= bus.operation;
          a_q    <= bus.operand_1;
          b_q    <= bus.operand_2;
          acc_q  <= '0;
          i_q    <= '0;
          j_q    <= '0;
          rad_q  <= {bus.operand_1, {FBITS{1'b0}}};
          rem_q  <= '0;
          root_q <= '0;
          it_q   <= '0;
          res_q  <= '0;
          ovf_q  <= 1'b0;
          err_q  <= (bus.operation > 3'd3);
        end
        ADDSUB: begin
          res_q <= as_res;
          ovf_q <= as_ovf;
        end
        MUL_PP: begin
          acc_q <= acc_q + pp_sh;
          if (j_q == CW'(N-1)) begin
            j_q <= '0;
            i_q <= i_q + 1'b1;
          end else begin
            j_q <= j_q + 1'b1;
          end
        end
        MUL_SUM: begin
          res_q <= mul_res;
          ovf_q <= mul_ovf;
        end
        SQRT_IT: begin
          rem_q  <= rem_nxt;
          root_q <= root_nxt;
          rad_q  <= rad_q << 2;
          it_q   <= it_q + 1'b1;
          // Negative radicands still run every iteration to keep latency fixed.
          if (it_q == ITW'(ITER-1)) begin
            res_q <= a_q[WIDTH-1] ? '0 : WIDTH'(root_nxt);
            err_q <= a_q[WIDTH-1];
          end
        end
        FINISH: begin
          bus.result   <= res_q;
          bus.overflow <= ovf_q;
          bus.error    <= err_q;
          bus.done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fixed_point_alu.sv
// Directed-vector bench for fixed_point_alu at default parameters (Q21.10).
module tb_fixed_point_alu;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 clk = ~clk;

  fixed_point_alu_if #(.WIDTH(32)) bus();

  fixed_point_alu #(.WIDTH(32), .FBITS(10), .MUL_CHUNK(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Leaves the bench at the negedge following the accept edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.operation = op;
    bus.operand_1 = a;
    bus.operand_2 = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.operation = 3'd0;
    bus.operand_1 = ~a;
    bus.operand_2 = ~b;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.done && lat < 100);
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res,
                        input logic exp_ovf, input logic exp_err);
    int lat;
    issue(op, a, b);
    check({tag, " busy"}, bus.busy, 1);
    wait_done(lat);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " result"}, bus.result, exp_res);
    check({tag, " overflow"}, bus.overflow, exp_ovf);
    check({tag, " error"}, bus.error, exp_err);
    check({tag, " busy_low"}, bus.busy, 0);
    @(negedge clk);
    check({tag, " done_pulse"}, bus.done, 0);
    check({tag, " held"}, bus.result, exp_res);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int lat, dn, dcyc;
    logic [31:0] dres;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.operation = 3'd0;
    bus.operand_1 = '0;
    bus.operand_2 = '0;
    repeat (3) @(negedge clk);
    check("rst busy", bus.busy, 0);
    check("rst done", bus.done, 0);
    check("rst result", bus.result, 0);
    check("rst overflow", bus.overflow, 0);
    check("rst error", bus.error, 0);
    reset = 1'b0;

    run_op("add",       3'd0, 32'h0000_0A00, 32'h0000_0400, 2, 32'h0000_0E00, 0, 0);
    run_op("add_sat",   3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 2, 32'h7FFF_FFFF, 1, 0);
    run_op("sub_sat",   3'd1, 32'h8000_0000, 32'h0000_0001, 2, 32'h8000_0000, 1, 0);
    run_op("sub",       3'd1, 32'h0000_0400, 32'h0000_0C00, 2, 32'hFFFF_F800, 0, 0);
    run_op("mul",       3'd2, 32'hFFFF_FA00, 32'h0000_0800, 6, 32'hFFFF_F400, 0, 0);
    run_op("mul_big",   3'd2, 32'h0010_0000, 32'h0010_0000, 6, 32'h4000_0000, 0, 0);
    run_op("mul_sat",   3'd2, 32'h0020_0000, 32'h0020_0000, 6, 32'h7FFF_FFFF, 1, 0);
    run_op("mul_nsat",  3'd2, 32'hFFE0_0000, 32'h0020_0000, 6, 32'h8000_0000, 1, 0);
    run_op("mul_min",   3'd2, 32'h8000_0000, 32'h0000_0400, 6, 32'h8000_0000, 0, 0);
    run_op("mul_zero",  3'd2, 32'h0000_0000, 32'h8000_0000, 6, 32'h0000_0000, 0, 0);
    run_op("mul_trunc", 3'd2, 32'hFFFF_FFFF, 32'h0000_0200, 6, 32'h0000_0000, 0, 0);
    run_op("sqrt4",     3'd3, 32'h0000_1000, 32'hDEAD_BEEF, 22, 32'h0000_0800, 0, 0);
    run_op("sqrt2",     3'd3, 32'h0000_0800, 32'h0000_0000, 22, 32'h0000_05A8, 0, 0);
    run_op("sqrt_neg",  3'd3, 32'hFFFF_FC00, 32'h0000_0000, 22, 32'h0000_0000, 0, 1);
    run_op("illegal",   3'd5, 32'h0000_1234, 32'h0000_5678, 1, 32'h0000_0000, 0, 1);

    // A second start while the multiplier is busy must be dropped.
    issue(3'd2, 32'hFFFF_FA00, 32'h0000_0800);
    dn = 0; dcyc = 0; dres = '0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (bus.done) begin
        dn++;
        dcyc = k;
        dres = bus.result;
      end
      bus.start = (k == 2);
      bus.operation = 3'd0;
      bus.operand_1 = 32'h0000_0400;
      bus.operand_2 = 32'h0000_0400;
    end
    bus.start = 1'b0;
    check("ignore done_count", dn, 1);
    check("ignore done_cycle", dcyc, 6);
    check("ignore result", dres, 32'hFFFF_F400);

    // Start held during the done cycle is taken on the very next edge.
    issue(3'd2, 32'h0000_0800, 32'h0000_0800);
    wait_done(lat);
    check("b2b mul latency", lat, 6);
    check("b2b mul result", bus.result, 32'h0000_1000);
    bus.start = 1'b1;
    bus.operation = 3'd0;
    bus.operand_1 = 32'h0000_0A00;
    bus.operand_2 = 32'h0000_0400;
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b add busy", bus.busy, 1);
    wait_done(lat);
    check("b2b add latency", lat, 2);
    check("b2b add result", bus.result, 32'h0000_0E00);

    issue(3'd3, 32'h0000_1000, 32'h0000_0000);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst busy", bus.busy, 0);
    check("midrst done", bus.done, 0);
    check("midrst result", bus.result, 0);
    reset = 1'b0;
    repeat (25) @(negedge clk);
    check("midrst no_done", bus.done, 0);
    run_op("post_rst", 3'd0, 32'h0000_0400, 32'h0000_0400, 2, 32'h0000_0800, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
